// File: rtl/edabk_uart_pkg.sv
// edabk_uart_pkg: shared FSM states, default payload width and counter width helper
package edabk_uart_pkg;
  localparam int CFG_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} arb_state_e;
  // a zero-length count still needs a one-bit register
  function automatic int cnt_w(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/edabk_rr_picker.sv
// edabk_rr_picker: combinational round-robin winner search starting at rr_ptr
//   req/rr_ptr/enable in; win_oh (one-hot), win_idx, win_valid out
module edabk_rr_picker #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             win_valid
);
  // scan from the far end so the position nearest rr_ptr is written last and wins
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % N_REQ]) win_idx = IW'((int'(rr_ptr) + i) % N_REQ);
    win_valid = enable & |req;
    win_oh = '0;
    win_oh[win_idx] = win_valid;
  end
endmodule

// File: rtl/edabk_tx_arbiter.sv
// edabk_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ requesters
//   in : bclk, reset, enable, req, req_data, req_parity, tx_finish
//   out: ack, err, gnt, busy, tx_start, tx_data, tx_parity (all registered)
module edabk_tx_arbiter
  import edabk_uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = CFG_DATA_WIDTH,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        bclk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_parity,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            err,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_parity,
  input  logic                        tx_finish
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int GW = cnt_w(GAP_CYCLES);
  arb_state_e state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d, win_oh;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic tx_start_q, tx_start_d, tx_parity_q, tx_parity_d, busy_q, busy_d, win_valid, done;
  logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, win_idx;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  edabk_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req(req), .rr_ptr(rr_q), .enable(enable),
    .win_oh(win_oh), .win_idx(win_idx), .win_valid(win_valid)
  );
  // finish has priority over timeout, so err only flags a genuine abort
  assign done = tx_finish || tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ack_d = '0;
    err_d = '0;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    tx_parity_d = tx_parity_q;
    idx_d = idx_q;
    rr_d = rr_q;
    tcnt_d = tcnt_q;
    gcnt_d = gcnt_q;
    case (state_q)
      IDLE: if (win_valid) begin
        state_d = START;
        gnt_d = win_oh;
        idx_d = win_idx;
        tx_start_d = 1'b1;
        tx_data_d = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        tx_parity_d = req_parity[win_idx];
      end
      START: begin
        state_d = BUSY;
        tcnt_d = '0;
      end
      BUSY: begin
        tcnt_d = tcnt_q + TW'(1);
        if (done) begin
          ack_d = gnt_q;
          err_d = tx_finish ? '0 : gnt_q;
          rr_d = idx_q == IW'(N_REQ - 1) ? '0 : idx_q + IW'(1);
          gnt_d = '0;
          gcnt_d = '0;
          state_d = GAP_CYCLES > 0 ? GAP : IDLE;
        end
      end
      default: begin
        gcnt_d = gcnt_q + GW'(1);
        state_d = gcnt_q == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      err_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      tx_parity_q <= 1'b0;
      busy_q <= 1'b0;
      idx_q <= '0;
      rr_q <= '0;
      tcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      err_q <= err_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
      tx_parity_q <= tx_parity_d;
      busy_q <= busy_d;
      idx_q <= idx_d;
      rr_q <= rr_d;
      tcnt_q <= tcnt_d;
      gcnt_q <= gcnt_d;
    end
  end
  assign gnt = gnt_q;
  assign ack = ack_q;
  assign err = err_q;
  assign busy = busy_q;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign tx_parity = tx_parity_q;
endmodule

// File: tb/tb_edabk_tx_arbiter.sv
// tb_edabk_tx_arbiter: directed checks of grant order, latency, gap, timeout, enable and reset
module tb_edabk_tx_arbiter;
  localparam int T = 1024;
  localparam int G = 16;
  logic bclk, reset, enable, tx_finish;
  logic [3:0] req, req_parity, ack, err, gnt;
  logic [31:0] req_data;
  logic busy, tx_start, tx_parity;
  logic [7:0] tx_data;
  int n_chk = 0, n_pass = 0;
  edabk_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .bclk(bclk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
    .req_parity(req_parity), .ack(ack), .err(err), .gnt(gnt), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_parity(tx_parity), .tx_finish(tx_finish)
  );
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge bclk);
    #1;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_start && n < 200);
    if (!tx_start) chk("start_seen", 0, 1);
  endtask
  task automatic finish_after(input int d);
    repeat (d) step();
    tx_finish = 1'b1;
    step();
    tx_finish = 1'b0;
  endtask
  initial begin
    int n, k, starts;
    logic [3:0] acc;
    reset = 1'b1; enable = 1'b1; tx_finish = 1'b0; req = '0; req_data = '0; req_parity = '0;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", tx_data, 0);
    // single request
    req_data[15:8] = 8'hA5; req_parity = 4'b0010; req = 4'b0010;
    step();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_par", tx_parity, 1);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_busy", busy, 1);
    req = '0;
    step();
    chk("t1_start_pulse", tx_start, 0);
    finish_after(158);
    chk("t1_ack", ack, 4'b0010);
    chk("t1_err", err, 0);
    chk("t1_gnt_clr", gnt, 0);
    step();
    chk("t1_ack_fall", ack, 0);
    repeat (14) step();
    chk("t1_gap_busy", busy, 1);
    step();
    chk("t1_idle", busy, 0);
    // round robin with all requesting
    reset = 1'b1; step(); reset = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_parity = 4'b0101; req = 4'b1111;
    wait_start(n);
    chk("t2_first_lat", n, 1);
    for (int i = 0; i < 5; i++) begin
      k = i % 4;
      chk("t2_gnt", gnt, 1 << k);
      chk("t2_data", tx_data, 8'h10 + k);
      chk("t2_par", tx_parity, (k % 2 == 0) ? 1 : 0);
      finish_after(3);
      chk("t2_ack", ack, 1 << k);
      chk("t2_err", err, 0);
      if (i < 4) begin
        wait_start(n);
        chk("t2_gap", n, G + 1);
      end
    end
    req = '0;
    repeat (20) step();
    chk("t2_idle", busy, 0);
    // timeout on requester 2
    req = 4'b0100;
    wait_start(n);
    chk("t3_gnt", gnt, 4'b0100);
    req = '0;
    step();
    repeat (T - 1) step();
    chk("t3_no_early_ack", ack, 0);
    step();
    chk("t3_ack", ack, 4'b0100);
    chk("t3_err", err, 4'b0100);
    chk("t3_gnt_clr", gnt, 0);
    req = 4'b1111;
    wait_start(n);
    chk("t3_regrant_lat", n, G + 1);
    chk("t3_rr_next", gnt, 4'b1000);
    // finish coincides with timeout expiry
    step();
    repeat (T - 1) step();
    tx_finish = 1'b1;
    step();
    tx_finish = 1'b0;
    chk("t4_ack", ack, 4'b1000);
    chk("t4_err", err, 0);
    // enable gating
    enable = 1'b0;
    starts = 0;
    repeat (40) begin
      step();
      starts += int'(tx_start);
    end
    chk("t5_no_start", starts, 0);
    chk("t5_idle", busy, 0);
    enable = 1'b1;
    wait_start(n);
    chk("t5_lat", n, 1);
    chk("t5_gnt", gnt, 4'b0001);
    enable = 1'b0;
    finish_after(5);
    chk("t5_ack", ack, 4'b0001);
    // reset mid-frame
    repeat (20) step();
    enable = 1'b1;
    wait_start(n);
    chk("t6_gnt_pre", gnt, 4'b0010);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = '0;
    chk("t6_gnt", gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_start", tx_start, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_par", tx_parity, 0);
    chk("t6_ack", ack, 0);
    chk("t6_err", err, 0);
    tx_finish = 1'b1;
    acc = '0;
    step();
    tx_finish = 1'b0;
    acc |= ack;
    repeat (20) begin
      step();
      acc |= ack;
    end
    chk("t6_no_ack", acc, 0);
    chk("t6_stray_idle", busy, 0);
    req = 4'b1000;
    wait_start(n);
    chk("t6_lat", n, 1);
    chk("t6_gnt3", gnt, 4'b1000);
    chk("t6_data3", tx_data, 8'h13);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/edabk_tx_arbiter.md
Name: edabk_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter (transmitter controller plus datapath) between N_REQ requesters. It picks one pending requester, registers that requester's byte and parity option, and pulses the transmitter start. It then waits for the transmitter's finish pulse, returns a per-requester ack, and enforces an inter-frame idle gap. A watchdog aborts a frame if finish never arrives. Sits between client logic and the transmitter, on the baud clock domain.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, `CFG_DATA_WIDTH (8), bits per frame payload
GAP_CYCLES, 16, idle bclk cycles inserted after each frame (0 = none)
TIMEOUT_CYCLES, 1024, max bclk cycles in BUSY before abort (must be > 0)

Ports:
bclk  in  1  baud clock; all logic on posedge
reset  in  1  synchronous reset, active-high
enable  in  1  1 = arbitration allowed; 0 = no new grants (frame in flight completes)
req  in  N_REQ  level request per requester; held until ack
req_data  in  N_REQ*DATA_WIDTH  requester k payload at [k*DATA_WIDTH +: DATA_WIDTH]
req_parity  in  N_REQ  requester k parity-bit enable
ack  out  N_REQ  one-cycle one-hot pulse: frame for requester k ended
err  out  N_REQ  coincident with ack; 1 = frame aborted by timeout
gnt  out  N_REQ  one-hot current owner; 0 when idle
busy  out  1  1 in any state other than IDLE
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  DATA_WIDTH  registered payload, stable from START until return to IDLE
tx_parity  out  1  registered parity enable, same stability as tx_data
tx_finish  in  1  transmitter finish pulse

Behaviour:
- All outputs are registered. Reset (when reset=1 at posedge) forces state=IDLE, gnt=0, ack=0, err=0, tx_start=0, tx_data=0, tx_parity=0, busy=0, rr_ptr=0, counters=0. Reset mid-frame abandons the frame with no ack. The transmitter must be reset with it.
- States: IDLE, START, BUSY, GAP.
- IDLE: if enable & |req, the winner is the first k with req[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ. Next edge: gnt=onehot(k); tx_data/tx_parity captured from requester k; tx_start=1; busy=1; state=START. Otherwise stay.
- START: exactly one cycle. Next edge: tx_start=0, state=BUSY, timeout counter cleared.
- BUSY: counter increments each cycle.
  - On tx_finish=1: next edge ack[k]=1, err[k]=0, rr_ptr=(k+1) mod N_REQ, gnt=0.
  - On counter reaching TIMEOUT_CYCLES-1 without tx_finish: the same update happens, but with err[k]=1.
  - Either way, state=GAP if GAP_CYCLES>0, else IDLE.
  - tx_finish and timeout in the same cycle: finish wins, err=0.
- GAP: hold GAP_CYCLES cycles (gap counter), then IDLE. ack/err fall after one cycle. busy stays 1 until IDLE.
- Latency: req seen in IDLE at edge t gives tx_start high during t+1. tx_finish at edge t gives ack high during t+1. Earliest re-grant is GAP_CYCLES+1 cycles after ack.
- tx_finish outside BUSY is ignored. req dropping after grant does not cancel the frame; ack still pulses. A requester must not drop req before grant (undefined which data is sent is avoided by capture at grant).
- enable=0 only blocks the IDLE grant decision.
- rr_ptr only advances on frame completion, giving starvation-free fairness. With N_REQ requesters all pending, each is served once per N_REQ frames.
- Counter widths are $clog2(TIMEOUT_CYCLES+1) and $clog2(GAP_CYCLES+1). No wrap is possible because the counters clear on entry.

Decomposition:
- Shared package edabk_uart_pkg: state enum (IDLE, START, BUSY, GAP), width helper constants. Defaults come from edabk_uart_transceiver_define.svh.
- One sub-module: edabk_rr_picker. Combinational inputs are req vector, rr_ptr and enable; outputs are a one-hot winner and its index, plus a valid flag. Parameterised by N_REQ.

Test Plan:
1. Single request: req=4'b0010, data[1]=8'hA5, parity[1]=1. Expect tx_start one cycle after req, tx_data=8'hA5, tx_parity=1, gnt=4'b0010. Model tx_finish after 160 cycles; expect ack=4'b0010, err=0 next cycle, then busy low after 16 GAP cycles.
2. All four requesting continuously, rr_ptr=0. Expect grant order 0,1,2,3,0. Each ack precedes the next tx_start by exactly GAP_CYCLES+1 cycles.
3. Timeout: grant requester 2, never assert tx_finish. Expect ack[2]=1 and err[2]=1 exactly TIMEOUT_CYCLES cycles after BUSY entry. rr_ptr advances to 3.
4. Simultaneous: tx_finish on the same cycle the timeout count expires. Expect ack with err=0.
5. enable=0 with req=4'b1111. Expect no tx_start. Set enable=1 and expect a grant to rr_ptr. Dropping enable mid-frame still yields an ack.
6. Reset mid-BUSY: reset=1 for one cycle. Expect all outputs 0 and no ack. Then req=4'b1000 yields a grant to 3 with rr_ptr reset to 0. A stray tx_finish in IDLE is ignored.
